// File: rtl/rx_pkg.sv
// Shared types and helpers for the UART receive sequencer.
//   state_t : receive FSM states
//   DS_5/DS_7/DS_8 : supported data-bits-per-frame codes
//   eff_ds() : maps any data_size code onto a supported frame length
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    BITS     = 3'd2,
    STOP_CHK = 3'd3,
    LOAD     = 3'd4
  } state_t;

  localparam logic [3:0] DS_5 = 4'd5;
  localparam logic [3:0] DS_7 = 4'd7;
  localparam logic [3:0] DS_8 = 4'd8;

  // Unsupported sizes fall back to 8 data bits.
  function automatic logic [3:0] eff_ds(input logic [3:0] data_size);
    case (data_size)
      DS_5:    return DS_5;
      DS_7:    return DS_7;
      default: return DS_8;
    endcase
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the UART receive sequencer.
// Counts 0..wrap_i while enabled and wraps to 0; roll_o flags the wrap cycle.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   en_i       : count enable
//   clr_i      : synchronous clear (has priority over en_i)
//   wrap_i     : terminal count (bit period - 1)
//   cnt_o      : current count
//   roll_o     : high in the cycle the count equals wrap_i while enabled
module rx_bit_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] cnt_o,
  output logic         roll_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign roll_o = en_i & (cnt_q == wrap_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = roll_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_sequencer.sv
// UART receive control unit. Synchronises the serial line, detects the start
// bit, times each bit, pulses shift_strobe into the external 9-bit data+stop
// shift register, then checks the stop bit and either pulses load_buffer or
// raises a sticky framing_error.
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   serial_in     : raw serial line (idle high, asynchronous)
//   data_size     : data bits per frame (5, 7, 8; others treated as 8)
//   bit_period    : clocks per bit (clamped to at least MIN_BP)
//   stop_bit      : stop-bit output of the shift register
//   shift_strobe  : one-cycle pulse, shift register samples the line
//   load_buffer   : one-cycle pulse, packet data valid
//   framing_error : sticky, last frame had a zero stop bit
//   rx_busy       : high from start detect until back in IDLE
// Build option:
//   START_VALIDATE_EN : re-sample the line mid start bit and abandon the frame
//                       if it is already high again (glitch rejection).
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int BP_W   = 14,
  parameter int MIN_BP = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            serial_in,
  input  logic [3:0]      data_size,
  input  logic [BP_W-1:0] bit_period,
  input  logic            stop_bit,
  output logic            shift_strobe,
  output logic            load_buffer,
  output logic            framing_error,
  output logic            rx_busy
);

  localparam logic [BP_W-1:0] MIN_BP_V = BP_W'(MIN_BP);

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [3:0]      ds_q, ds_d;
  logic [BP_W-1:0] bp_q, bp_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic            stop_ok_q, stop_ok_d;
  logic            fe_q, fe_d;

  logic            start_edge;
  logic [BP_W-1:0] bp_clamp;
  logic [BP_W-1:0] half_bp;
  logic [3:0]      nstrb;
  logic            tmr_en, tmr_clr, tmr_roll;
  logic [BP_W-1:0] tmr_cnt;
  logic            strobe;

  // Two-flop synchroniser plus one edge flop; all reset to the idle level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge = (state_q == IDLE) & prev_q & ~sync2_q;
  assign bp_clamp   = (bit_period < MIN_BP_V) ? MIN_BP_V : bit_period;
  assign half_bp    = bp_q >> 1;
  assign nstrb      = ds_q + 4'd1;

  rx_bit_timer #(.W(BP_W)) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .en_i   (tmr_en),
    .clr_i  (tmr_clr),
    .wrap_i (bp_q - BP_W'(1)),
    .cnt_o  (tmr_cnt),
    .roll_o (tmr_roll)
  );

  always_comb begin
    state_d   = state_q;
    ds_d      = ds_q;
    bp_d      = bp_q;
    bitcnt_d  = bitcnt_q;
    stop_ok_d = stop_ok_q;
    fe_d      = fe_q;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;
    strobe    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start_edge) begin
          // Frame parameters are frozen here for the whole frame.
          state_d   = START;
          ds_d      = eff_ds(data_size);
          bp_d      = bp_clamp;
          fe_d      = 1'b0;
          stop_ok_d = 1'b0;
        end
      end
      START: begin
        tmr_en = 1'b1;
        // Timer restarts so the first wrap lands one bit period after mid start bit.
        if (tmr_cnt == half_bp - BP_W'(1)) begin
          tmr_clr  = 1'b1;
          bitcnt_d = 4'd0;
`ifdef START_VALIDATE_EN
          state_d  = sync2_q ? IDLE : BITS;
`else
          state_d  = BITS;
`endif
        end
      end
      BITS: begin
        tmr_en = 1'b1;
        if (tmr_roll) begin
          strobe   = 1'b1;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_d == nstrb) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        // Shift register has absorbed the last strobe; stop bit is valid now.
        stop_ok_d = stop_bit;
        fe_d      = ~stop_bit;
        state_d   = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      ds_q      <= '0;
      bp_q      <= '0;
      bitcnt_q  <= '0;
      stop_ok_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ds_q      <= ds_d;
      bp_q      <= bp_d;
      bitcnt_q  <= bitcnt_d;
      stop_ok_q <= stop_ok_d;
      fe_q      <= fe_d;
    end
  end

  // All outputs decode registered state only; the start-edge term lets busy
  // rise and a stale framing error clear in the detect cycle itself.
  assign shift_strobe  = strobe;
  assign load_buffer   = (state_q == LOAD) & stop_ok_q;
  assign framing_error = fe_q & ~start_edge;
  assign rx_busy       = (state_q != IDLE) | start_edge;

endmodule

// File: tb/tb_rx_sequencer.sv
// Self-checking bench for rx_sequencer: table-driven frames, randomized frames
// against an arithmetic timing model, and hand-written corner sequences
// (glitch, line held low, mid-frame input change, reset mid-frame).
module tb_rx_sequencer;
  localparam int BP_W = 14;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            serial_in = 1'b1;
  logic [3:0]      data_size = 4'd8;
  logic [BP_W-1:0] bit_period = 14'd10;
  logic            stop_bit;
  logic            shift_strobe, load_buffer, framing_error, rx_busy;

  rx_sequencer #(.BP_W(BP_W), .MIN_BP(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_size     (data_size),
    .bit_period    (bit_period),
    .stop_bit      (stop_bit),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift register stand-in: samples the line through its own 2-flop delay,
  // LSB first, so after a full frame sr[8] is the stop bit.
  logic       d1 = 1'b1, d2 = 1'b1;
  logic [8:0] sr = '0;
  always @(posedge clk) begin
    d1 <= serial_in;
    d2 <= d1;
    if (shift_strobe) sr <= {d2, sr[8:1]};
  end
  assign stop_bit = sr[8];

  bit fe_log   [65536];
  bit busy_log [65536];
  int strobe_q [$];
  int load_q   [$];
  always @(negedge clk) begin
    if (cyc < 65536) begin
      fe_log[cyc]   <= framing_error;
      busy_log[cyc] <= rx_busy;
    end
    if (shift_strobe) strobe_q.push_back(cyc);
    if (load_buffer)  load_q.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drives one frame; bit i starts bp cycles after bit i-1. The DUT sees the
  // falling edge two flops later, so E = drive cycle + 2.
  task automatic send_frame(input int bp, input int nd, input logic [7:0] data,
                            input bit stop, input bit hold_low, output int e);
    @(posedge clk); #1;
    serial_in = 1'b0;
    e = cyc + 2;
    repeat (bp) @(posedge clk);
    #1;
    for (int i = 0; i < nd; i++) begin
      serial_in = data[i];
      repeat (bp) @(posedge clk);
      #1;
    end
    serial_in = stop;
    repeat (bp) @(posedge clk);
    #1;
    serial_in = hold_low ? 1'b0 : 1'b1;
  endtask

  // Expected timing: strobe k at E + bp/2 + k*bp; S = last strobe;
  // load at S+2 when stop is 1; framing_error = !stop from S+2; busy low at S+3.
  task automatic check_frame(input int e, input int bp, input int n, input bit stop,
                             input logic [7:0] data, input string name);
    int h, s, ds, lim;
    logic [7:0] got, mask;
    h = bp / 2;
    s = e + h + n * bp;
    ds = n - 1;
    chk({name, " strobe count"}, strobe_q.size(), n);
    lim = (strobe_q.size() < n) ? strobe_q.size() : n;
    for (int k = 1; k <= lim; k++)
      chk({name, " strobe offset"}, strobe_q[k-1] - e, h + k * bp);
    chk({name, " load count"}, load_q.size(), stop ? 1 : 0);
    if (load_q.size() > 0) chk({name, " load offset"}, load_q[0] - e, s + 2 - e);
    chk({name, " fe at S+1"}, int'(fe_log[s+1]), 0);
    chk({name, " fe at S+2"}, int'(fe_log[s+2]), stop ? 0 : 1);
    chk({name, " busy at E+1"}, int'(busy_log[e+1]), 1);
    chk({name, " busy at S+2"}, int'(busy_log[s+2]), 1);
    chk({name, " busy at S+3"}, int'(busy_log[s+3]), 0);
    mask = 8'hFF >> (8 - ds);
    got  = sr[7:0] >> (8 - ds);
    chk({name, " data"}, int'(got), int'(data & mask));
    chk({name, " stop sampled"}, int'(sr[8]), int'(stop));
  endtask

  task automatic run_frame(input int bp_in, input int ds_in, input logic [7:0] data,
                           input bit stop, input int exp_bp, input int exp_n,
                           input string name, output int e);
    bit_period = BP_W'(bp_in);
    data_size  = 4'(ds_in);
    strobe_q.delete();
    load_q.delete();
    send_frame(exp_bp, exp_n - 1, data, stop, 1'b0, e);
    repeat (exp_bp + 10) @(posedge clk);
    #1;
    check_frame(e, exp_bp, exp_n, stop, data, name);
  endtask

  typedef struct {
    int         bp_in;
    int         ds_in;
    logic [7:0] data;
    bit         stop;
    int         exp_bp;
    int         exp_n;
  } vec_t;

  vec_t tbl [9];
  int   e_row [9];
  int   e, t, eb, eds, bpr, dsr;
  logic [7:0] dr;
  bit   sr_stop;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10, 8, 8'hA5, 1'b1, 10, 9};
    tbl[1] = '{10, 5, 8'h13, 1'b1, 10, 6};
    tbl[2] = '{10, 8, 8'h5A, 1'b0, 10, 9};
    tbl[3] = '{10, 7, 8'h2B, 1'b1, 10, 8};
    tbl[4] = '{ 2, 8, 8'hC3, 1'b1,  4, 9};
    tbl[5] = '{10, 3, 8'h96, 1'b1, 10, 9};
    tbl[6] = '{ 0, 5, 8'h1F, 1'b1,  4, 6};
    tbl[7] = '{17, 7, 8'h55, 1'b0, 17, 8};
    tbl[8] = '{ 5, 8, 8'h81, 1'b1,  5, 9};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset shift_strobe", int'(shift_strobe), 0);
    chk("reset load_buffer", int'(load_buffer), 0);
    chk("reset framing_error", int'(framing_error), 0);
    chk("reset rx_busy", int'(rx_busy), 0);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].bp_in, tbl[i].ds_in, tbl[i].data, tbl[i].stop,
                tbl[i].exp_bp, tbl[i].exp_n, $sformatf("vec%0d", i), e_row[i]);
    end
    // Frame 2 ended with a framing error; frame 3's start edge must clear it.
    chk("fe held until next start", int'(fe_log[e_row[3]-1]), 1);
    chk("fe cleared at start edge", int'(fe_log[e_row[3]]), 0);

    // Line held low after a bad stop bit must not retrigger
    bit_period = 14'd10;
    data_size  = 4'd8;
    strobe_q.delete();
    load_q.delete();
    send_frame(10, 8, 8'h0F, 1'b0, 1'b1, e);
    repeat (20) @(posedge clk);
    #1;
    check_frame(e, 10, 9, 1'b0, 8'h0F, "hold_low");
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("hold_low no retrigger strobes", strobe_q.size(), 9);
    chk("hold_low idle busy", int'(rx_busy), 0);
    serial_in = 1'b1;
    repeat (10) @(posedge clk);

    // Mid-frame changes of bit_period and data_size are ignored
    bit_period = 14'd10;
    data_size  = 4'd8;
    strobe_q.delete();
    load_q.delete();
    fork
      send_frame(10, 8, 8'h6E, 1'b1, 1'b0, e);
      begin
        repeat (30) @(posedge clk);
        #2;
        bit_period = 14'd3;
        data_size  = 4'd5;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check_frame(e, 10, 9, 1'b1, 8'h6E, "midframe");

    // Start glitch, 2 clocks low, bp = 16
    bit_period = 14'd16;
    data_size  = 4'd8;
    strobe_q.delete();
    load_q.delete();
    @(posedge clk); #1;
    serial_in = 1'b0;
    e = cyc + 2;
    repeat (2) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (200) @(posedge clk);
    #1;
`ifdef START_VALIDATE_EN
    chk("glitch strobes", strobe_q.size(), 0);
    chk("glitch busy at E+1", int'(busy_log[e+1]), 1);
    chk("glitch busy at E+10", int'(busy_log[e+10]), 0);
    chk("glitch fe", int'(framing_error), 0);
`else
    check_frame(e, 16, 9, 1'b1, 8'hFF, "glitch");
`endif

    // Reset asserted at the 4th strobe aborts silently
    bit_period = 14'd10;
    data_size  = 4'd8;
    strobe_q.delete();
    load_q.delete();
    fork
      send_frame(10, 8, 8'h3C, 1'b1, 1'b0, e);
      begin
        t = 0;
        while (strobe_q.size() < 4 && t < 3000) begin
          @(negedge clk);
          #1;
          t++;
        end
        chk("reset test reached 4th strobe", int'(strobe_q.size() >= 4), 1);
        n_rst = 1'b0;
        #1;
        chk("midreset shift_strobe", int'(shift_strobe), 0);
        chk("midreset load_buffer", int'(load_buffer), 0);
        chk("midreset framing_error", int'(framing_error), 0);
        chk("midreset rx_busy", int'(rx_busy), 0);
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("aborted frame no load", load_q.size(), 0);
    chk("aborted frame no fe", int'(framing_error), 0);
    chk("aborted frame idle", int'(rx_busy), 0);
    run_frame(10, 8, 8'hC6, 1'b1, 10, 9, "post_reset", e);

    // Randomized frames against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      bpr = int'($urandom_range(24, 0));
      dsr = int'($urandom_range(15, 0));
      dr  = 8'($urandom);
      sr_stop = ($urandom_range(3, 0) != 0);
      eb  = (bpr < 4) ? 4 : bpr;
      eds = (dsr == 5 || dsr == 7) ? dsr : 8;
      run_frame(bpr, dsr, dr, sr_stop, eb, eds + 1, $sformatf("rand%0d", r), e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
